encoder: RTL and testbench
==========================

// Module: encoder
// PURPOSE
//  Registered 8-to-3 binary encoder. Converts an 8-bit one-hot request vector into the
//  3-bit index of the asserted bit, and flags whether any bit is set. It sits between
//  request/select logic and index-consuming datapaths (mux selects, address generation).
//  Multi-hot inputs are resolved by fixed priority: the highest index wins.
// PARAMETERS
//  IN_W   8                 input vector width; must be a power of two and >= 2
//  OUT_W  $clog2(IN_W) = 3  encoded index width; derived, not overridable
// PORTS
//  clk    in   1      single system clock; all state updates on its rising edge
//  rst    in   1      reset; synchronous, active-high
//  in     in   IN_W   request vector, one-hot expected (bit i set => index i)
//  out    out  OUT_W  encoded index of the highest set bit of in, registered
//  valid  out  1      1 when the sampled in had at least one bit set, registered
//  err    out  1      multi-hot flag; present only with ENCODER_ONEHOT_CHECK_EN
// BEHAVIOUR
//  - Clocking: one clock, clk. Reset is synchronous and active-high on rst.
//  - Reset: while rst=1 at a rising edge, out<=0, valid<=0, err<=0. rst overrides in.
//  - Latency: exactly 1 cycle. in is sampled at edge N; out/valid/err reflect it after edge N.
//  - Encoding: out = highest index i with in[i]=1. 8'b1000_0000->7, 8'b0100_0000->6,
//    8'b0010_0000->5, 8'b0001_0000->4, 8'b0000_1000->3, 8'b0000_0100->2,
//    8'b0000_0010->1, 8'b0000_0001->0.
//  - Zero input: in=0 -> out<=0, valid<=0. out=0 with valid=1 means bit 0 was set.
//  - Multi-hot: highest set bit wins, e.g. 8'b1000_0001 -> out=7, valid=1.
//  - No handshake and no back-pressure. A new result is produced every cycle.
//  - No internal state other than the output registers. Outputs never hold stale data
//    past one cycle after in changes.
//  - Reset mid-operation: the next edge with rst=1 clears the outputs. The first edge with
//    rst=0 samples in normally, so there is no recovery delay.
//  - X on in: no requirement on the values produced. Outputs must recover on the first clean sample.
// CONFIGURATION
//  - Macro ENCODER_ONEHOT_CHECK_EN.
//  - When defined: port err exists. err<=1 when the sampled in has two or more bits set,
//    otherwise err<=0. err has the same 1-cycle latency as out/valid and resets to 0.
//    out/valid behaviour is unchanged.
//  - When undefined: port err and its logic are absent. All other behaviour is identical.
// STRUCTURE
//  - Package encoder_pkg holds:
//    - localparams ENC_IN_W=8 and ENC_OUT_W=3.
//    - typedef enc_in_t = logic [ENC_IN_W-1:0].
//    - typedef enc_idx_t = logic [ENC_OUT_W-1:0].
//  - Sub-module encoder_prio_comb: purely combinational.
//    - Inputs: in. Outputs: idx, any, multi.
//    - Scans from MSB down to produce the highest-set index.
//    - multi is computed as (in & (in-1)) != 0.
//  - encoder top: instantiates encoder_prio_comb and adds the clk/rst output registers
//    plus the macro-guarded err register.
// TESTING
//  - Reset: assert rst for 2 cycles with in=8'hFF -> out=0, valid=0 (err=0) throughout.
//  - One-hot sweep: apply 8'b1000_0000 down to 8'b0000_0001, 1 cycle apart ->
//    out = 7,6,5,4,3,2,1,0 one cycle later, with valid=1 each time.
//  - Zero: in=8'h00 -> out=0, valid=0 next cycle.
//    Then in=8'h01 -> out=0, valid=1 (distinguishes bit 0 from none).
//  - Priority: in=8'b1000_0001 -> out=7. in=8'b0011_0000 -> out=5.
//    With ENCODER_ONEHOT_CHECK_EN: err=1 for both, and err=0 for 8'b0000_1000.
//  - Mid-run reset: with in=8'h40 streaming and out=6, pulse rst for 1 cycle ->
//    out=0, valid=0 for that cycle. The following cycle out=6, valid=1 again.

Source files
------------

// File: rtl/encoder_pkg.sv
// ============================================================================
//  Module : encoder_pkg
//  Brief  : Shared widths and types for the registered priority encoder.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package encoder_pkg;

  localparam int ENC_IN_W  = 8;
  localparam int ENC_OUT_W = 3;

  typedef logic [ENC_IN_W-1:0]  enc_in_t;
  typedef logic [ENC_OUT_W-1:0] enc_idx_t;

endpackage

`default_nettype wire

// File: rtl/encoder_prio_comb.sv
// ============================================================================
//  Module : encoder_prio_comb
//  Brief  : Combinational highest-index-wins encoder with any/multi-hot flags.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module encoder_prio_comb
  import encoder_pkg::*;
#(
  parameter  int IN_W  = ENC_IN_W,
  localparam int OUT_W = $clog2(IN_W)
) (
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  logic             w_found;
  logic [IN_W-1:0]  w_below;

  // Walk down from the MSB; the first set bit encountered is the winner.
  always_comb begin
    idx     = '0;
    w_found = 1'b0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (!w_found && in[i]) begin
        idx     = OUT_W'(i);
        w_found = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit leaves something only when two or more were set.
  assign w_below = in - IN_W'(1);
  assign any     = |in;
  assign multi   = |(in & w_below);

endmodule

`default_nettype wire

// File: rtl/encoder.sv
// ============================================================================
//  Module : encoder
//  Brief  : Registered 8-to-3 priority encoder (1-cycle latency). Optional
//           multi-hot flag port err under ENCODER_ONEHOT_CHECK_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module encoder
  import encoder_pkg::*;
#(
  parameter  int IN_W  = ENC_IN_W,
  localparam int OUT_W = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
`ifdef ENCODER_ONEHOT_CHECK_EN
  output logic             err,
`endif
  output logic             valid
);

  logic [OUT_W-1:0] w_idx;
  logic             w_any;
  logic             w_multi;
  logic [OUT_W-1:0] r_out;
  logic             r_valid;

  encoder_prio_comb #(
    .IN_W (IN_W)
  ) u_prio (
    .in    (in),
    .idx   (w_idx),
    .any   (w_any),
    .multi (w_multi)
  );

  // Outputs are the only state; reset overrides whatever is on in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_out   <= w_idx;
      r_valid <= w_any;
    end
  end

  assign out   = r_out;
  assign valid = r_valid;

`ifdef ENCODER_ONEHOT_CHECK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_multi;
    end
  end

  assign err = r_err;
`else
  logic w_multi_unused;
  assign w_multi_unused = w_multi;
`endif

endmodule

`default_nettype wire

// File: tb/tb_encoder.sv
// ============================================================================
//  Module : tb_encoder
//  Brief  : Scoreboard bench for encoder; checks err when built with
//           ENCODER_ONEHOT_CHECK_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_encoder;
  import encoder_pkg::*;

  typedef struct {
    string    name;
    enc_in_t  stim;
    enc_idx_t out;
    logic     valid;
    logic     err;
  } exp_t;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  enc_in_t  in  = 8'hFF;
  enc_idx_t out;
  logic     valid;
  logic     err_obs;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

`ifdef ENCODER_ONEHOT_CHECK_EN
  logic err;
  encoder dut (.clk(clk), .rst(rst), .in(in), .out(out), .err(err), .valid(valid));
  assign err_obs = err;
`else
  encoder dut (.clk(clk), .rst(rst), .in(in), .out(out), .valid(valid));
  assign err_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  // Reference: index of the highest set bit is floor(log2(v)); err means popcount > 1.
  function automatic exp_t model(input logic r, input enc_in_t v, input string nm);
    exp_t e;
    e.name  = nm;
    e.stim  = v;
    e.out   = '0;
    e.valid = 1'b0;
    e.err   = 1'b0;
    if (!r && v != 0) begin
      e.out   = enc_idx_t'($clog2(int'(v) + 1) - 1);
      e.valid = 1'b1;
`ifdef ENCODER_ONEHOT_CHECK_EN
      e.err   = ($countones(v) > 1);
`endif
    end
    return e;
  endfunction

  task automatic step(input logic r, input enc_in_t v, input string nm);
    @(negedge clk);
    rst = r;
    in  = v;
    q.push_back(model(r, v, nm));
  endtask

  // Monitor: the DUT presents a result every cycle, one edge after each stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (out !== e.out || valid !== e.valid || err_obs !== e.err) begin
          failures++;
          $display("FAIL %s in=%h: got out=%0d valid=%b err=%b, want out=%0d valid=%b err=%b",
                   e.name, e.stim, out, valid, err_obs, e.out, e.valid, e.err);
        end
      end
    end
  end

  initial begin
    enc_in_t v;
    step(1'b1, 8'hFF, "reset0");
    step(1'b1, 8'hFF, "reset1");
    for (int i = 7; i >= 0; i--) begin
      v = enc_in_t'(1) << i;
      step(1'b0, v, "onehot");
    end
    step(1'b0, 8'h00, "zero");
    step(1'b0, 8'h01, "bit0");
    step(1'b0, 8'h81, "prio81");
    step(1'b0, 8'h30, "prio30");
    step(1'b0, 8'h08, "single08");
    step(1'b0, 8'h40, "stream40a");
    step(1'b0, 8'h40, "stream40b");
    step(1'b1, 8'h40, "midreset");
    step(1'b0, 8'h40, "recover40");
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(3))
        0:       v = enc_in_t'(1) << $urandom_range(7);
        1:       v = 8'h00;
        default: v = enc_in_t'($urandom);
      endcase
      step(($urandom_range(15) == 0), v, "random");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
